mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a fetch port and a data port share one memory.
// Data normally wins, but a bounded streak of data grants lets a waiting fetch through.
module mem_arbiter #(
  parameter int LATENCY       = 2,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_word,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_word,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } stateT;

  stateT      state;
  stateT      stateNext;
  logic [3:0] cnt;
  logic [3:0] streak;
  logic       owner;
  logic       anyReq;
  logic       dataWins;
  logic       lastCycle;

  // State register; reset is synchronous and active-low.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Arbitration decision and next-state logic.
  always_comb begin
    stateNext = state;
    anyReq    = if_req | dm_req;
    dataWins  = dm_req && !(if_req && (streak == 4'(MAX_DM_STREAK)));
    lastCycle = (cnt == 4'd1);
    unique case (state)
      IDLE:    if (anyReq) stateNext = WAIT;
      WAIT:    if (lastCycle) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Access datapath; owner is 1 for a data access, 0 for a fetch.
  always_ff @(posedge clock) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_word  <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      dm_rdata  <= 32'h0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      cnt       <= 4'd0;
      streak    <= 4'd0;
      owner     <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            mem_en <= 1'b1;
            cnt    <= 4'(LATENCY);
            owner  <= dataWins;
            if (dataWins) begin
              mem_we    <= dm_we;
              mem_word  <= dm_word;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              // A data win with fetch waiting implies streak is below the cap.
              if (if_req && (streak != 4'(MAX_DM_STREAK))) begin
                streak <= streak + 4'd1;
              end else if (!if_req) begin
                streak <= 4'd0;
              end
            end else begin
              mem_we    <= 1'b0;
              mem_word  <= 1'b1;
              mem_addr  <= if_addr;
              mem_wdata <= 32'h0;
              streak    <= 4'd0;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (lastCycle) begin
            if (owner) begin
              dm_ready <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at LATENCY=2 for arbitration,
// writes and reset, and a second at LATENCY=1 for back-to-back fetches.
module tb_mem_arbiter;

  typedef struct packed {
    logic        isData;
    logic [31:0] data;
  } expT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst;
  logic        ifReq, dmReq, dmWe, dmWord;
  logic [31:0] ifAddr, dmAddr, dmWdata;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;
  logic        ifReady, dmReady, memEn, memWe, memWord, stallIf, stallMem;

  logic        ifReqB;
  logic [31:0] ifAddrB;
  logic [31:0] ifRdataB, dmRdataB, memAddrB, memWdataB, memRdataB;
  logic        ifReadyB, dmReadyB, memEnB, memWeB, memWordB, stallIfB, stallMemB;

  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  expT expQ[$];
  expT expQB[$];
  expT eA, eB;
  logic [31:0] grantLog[$];
  int  memEnCycB[$];
  int  readyCycB[$];

  localparam logic [31:0] ORDER [10] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h10,
                                         32'h40, 32'h40, 32'h40, 32'h40, 32'h10};
  localparam logic [31:0] ADDRB [3] = '{32'h0, 32'h4, 32'h8};

  mem_arbiter #(.LATENCY(2), .MAX_DM_STREAK(4)) dut (
    .clock(clock), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
    .dm_req(dmReq), .dm_we(dmWe), .dm_word(dmWord), .dm_addr(dmAddr),
    .dm_wdata(dmWdata), .dm_rdata(dmRdata), .dm_ready(dmReady),
    .mem_en(memEn), .mem_we(memWe), .mem_word(memWord), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata),
    .stall_if(stallIf), .stall_mem(stallMem)
  );

  mem_arbiter #(.LATENCY(1), .MAX_DM_STREAK(4)) dutB (
    .clock(clock), .rst(rst),
    .if_req(ifReqB), .if_addr(ifAddrB), .if_rdata(ifRdataB), .if_ready(ifReadyB),
    .dm_req(1'b0), .dm_we(1'b0), .dm_word(1'b0), .dm_addr(32'h0),
    .dm_wdata(32'h0), .dm_rdata(dmRdataB), .dm_ready(dmReadyB),
    .mem_en(memEnB), .mem_we(memWeB), .mem_word(memWordB), .mem_addr(memAddrB),
    .mem_wdata(memWdataB), .mem_rdata(memRdataB),
    .stall_if(stallIfB), .stall_mem(stallMemB)
  );

  function automatic logic [31:0] romA(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h8C220004;
      32'h40:  return 32'h12345678;
      default: return 32'hA5A50000 | a;
    endcase
  endfunction

  assign memRdata  = romA(memAddr);
  assign memRdataB = 32'hB0000000 | memAddrB;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic dwd, input logic [31:0] da,
                               input logic [31:0] dd);
    ifReq = ir; ifAddr = ia; dmReq = dr; dmWe = dw; dmWord = dwd;
    dmAddr = da; dmWdata = dd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clock) begin
    if (memEn === 1'b1) grantLog.push_back(memAddr);
    if (ifReady === 1'b1 && dmReady === 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL A_dual_ready: got both ready expected one");
    end else if (ifReady === 1'b1 || dmReady === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL A_unexpected_ready: got ready expected none");
      end else begin
        eA = expQ.pop_front();
        checkOutput("A_ready_owner", {31'b0, dmReady}, {31'b0, eA.isData});
        checkOutput("A_rdata", dmReady ? dmRdata : ifRdata, eA.data);
      end
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance, also logging cycle timing.
  always @(negedge clock) begin
    if (memEnB === 1'b1) memEnCycB.push_back(cyc);
    if (dmReadyB === 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL B_dm_ready: got 1 expected 0");
    end
    if (ifReadyB === 1'b1) begin
      readyCycB.push_back(cyc);
      if (expQB.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL B_unexpected_ready: got ready expected none");
      end else begin
        eB = expQB.pop_front();
        checkOutput("B_rdata", ifRdataB, eB.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int readies;
    int w;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    ifReqB = 1'b0;
    ifAddrB = 32'h0;
    step();
    step();
    checkOutput("reset_mem_en", memEn, 0);
    checkOutput("reset_mem_addr", memAddr, 0);
    checkOutput("reset_if_rdata", ifRdata, 0);
    checkOutput("reset_dm_rdata", dmRdata, 0);
    checkOutput("reset_if_ready", ifReady, 0);
    checkOutput("reset_dm_ready", dmReady, 0);
    rst = 1'b1;

    // Single fetch, LATENCY=2.
    expQ.push_back({1'b0, 32'h8C220004});
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("t1_mem_en_grant", memEn, 1);
    checkOutput("t1_mem_addr", memAddr, 32'h10);
    checkOutput("t1_mem_we", memWe, 0);
    checkOutput("t1_stall_if", stallIf, 1);
    checkOutput("t1_if_ready_early", ifReady, 0);
    step();
    checkOutput("t1_mem_en_once", memEn, 0);
    checkOutput("t1_if_ready_early2", ifReady, 0);
    step();
    checkOutput("t1_if_ready", ifReady, 1);
    checkOutput("t1_if_rdata", ifRdata, 32'h8C220004);
    checkOutput("t1_stall_if_release", stallIf, 0);
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("t1_if_ready_pulse", ifReady, 0);
    checkOutput("t1_if_rdata_hold", ifRdata, 32'h8C220004);

    // Simultaneous requests: data first, fetch on the next IDLE edge.
    expQ.push_back({1'b1, 32'h12345678});
    expQ.push_back({1'b0, 32'h8C220004});
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    step();
    checkOutput("t2_mem_en", memEn, 1);
    checkOutput("t2_data_first", memAddr, 32'h40);
    checkOutput("t2_stall_mem", stallMem, 1);
    checkOutput("t2_stall_if_a", stallIf, 1);
    step();
    checkOutput("t2_stall_if_b", stallIf, 1);
    step();
    checkOutput("t2_dm_ready", dmReady, 1);
    checkOutput("t2_stall_mem_release", stallMem, 0);
    checkOutput("t2_stall_if_c", stallIf, 1);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    step();
    checkOutput("t2_done_no_grant", memEn, 0);
    checkOutput("t2_stall_if_d", stallIf, 1);
    step();
    checkOutput("t2_fetch_grant", memEn, 1);
    checkOutput("t2_fetch_addr", memAddr, 32'h10);
    step();
    step();
    checkOutput("t2_if_ready", ifReady, 1);
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    step();

    // Both held continuously: streak cap lets fetch in every fifth grant.
    grantLog.delete();
    for (int i = 0; i < 10; i++) begin
      if (ORDER[i] == 32'h10) expQ.push_back({1'b0, 32'h8C220004});
      else expQ.push_back({1'b1, 32'h12345678});
    end
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    readies = 0;
    for (int c = 0; c < 80 && readies < 10; c++) begin
      step();
      if (ifReady === 1'b1 || dmReady === 1'b1) readies++;
    end
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    step();
    step();
    checkOutput("t3_ready_count", readies, 10);
    checkOutput("t3_grant_count", grantLog.size(), 10);
    for (int i = 0; i < 10 && i < grantLog.size(); i++) begin
      checkOutput($sformatf("t3_grant_order_%0d", i), grantLog[i], ORDER[i]);
    end

    // Word write: ready still pulses, dm_rdata keeps the last read value.
    expQ.push_back({1'b1, 32'h12345678});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
    step();
    checkOutput("t4_mem_en", memEn, 1);
    checkOutput("t4_mem_we", memWe, 1);
    checkOutput("t4_mem_word", memWord, 1);
    checkOutput("t4_mem_addr", memAddr, 32'h8);
    checkOutput("t4_mem_wdata", memWdata, 32'hDEADBEEF);
    step();
    step();
    checkOutput("t4_dm_ready", dmReady, 1);
    checkOutput("t4_dm_rdata_kept", dmRdata, 32'h12345678);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("t4_mem_wdata_hold", memWdata, 32'hDEADBEEF);
    checkOutput("t4_dm_ready_pulse", dmReady, 0);

    // Reset one cycle after a grant abandons the access.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checkOutput("t5_grant", memEn, 1);
    rst = 1'b0;
    step();
    checkOutput("t5_mem_en", memEn, 0);
    checkOutput("t5_mem_we", memWe, 0);
    checkOutput("t5_mem_word", memWord, 0);
    checkOutput("t5_mem_addr", memAddr, 0);
    checkOutput("t5_mem_wdata", memWdata, 0);
    checkOutput("t5_if_rdata", ifRdata, 0);
    checkOutput("t5_dm_rdata", dmRdata, 0);
    checkOutput("t5_stall_if", stallIf, 1);
    step();
    checkOutput("t5_no_ready", ifReady, 0);
    expQ.push_back({1'b0, 32'h8C220004});
    rst = 1'b1;
    step();
    checkOutput("t5_resume_grant", memEn, 1);
    checkOutput("t5_resume_addr", memAddr, 32'h10);
    step();
    step();
    checkOutput("t5_if_ready", ifReady, 1);
    checkOutput("t5_if_rdata", ifRdata, 32'h8C220004);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // LATENCY=1 back-to-back fetches.
    for (int k = 0; k < 3; k++) expQB.push_back({1'b0, 32'hB0000000 | ADDRB[k]});
    ifReqB = 1'b1;
    ifAddrB = ADDRB[0];
    for (int k = 0; k < 3; k++) begin
      w = 0;
      do begin
        step();
        w++;
      end while (ifReadyB !== 1'b1 && w < 10);
      if (ifReadyB !== 1'b1) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL B_ready_timeout_%0d: got no ready expected ready", k);
      end
      if (k < 2) ifAddrB = ADDRB[k + 1];
      else ifReqB = 1'b0;
    end
    repeat (4) step();
    checkOutput("B_grant_count", memEnCycB.size(), 3);
    checkOutput("B_ready_count", readyCycB.size(), 3);
    for (int i = 0; i < 3 && i < memEnCycB.size() && i < readyCycB.size(); i++) begin
      checkOutput($sformatf("B_ready_latency_%0d", i), readyCycB[i] - memEnCycB[i], 1);
    end
    for (int i = 0; i + 1 < memEnCycB.size() && i < 2; i++) begin
      checkOutput($sformatf("B_grant_spacing_%0d", i), memEnCycB[i + 1] - memEnCycB[i], 3);
    end

    checkOutput("A_queue_drained", expQ.size(), 0);
    checkOutput("B_queue_drained", expQB.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
